// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, round constants and the key-schedule FSM encoding.
package aes_pkg;

  localparam int NK = 4;   // 32-bit words per AES-128 key
  localparam int NR = 10;  // AES-128 cipher rounds

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Round constants, top byte of each word; entry i belongs to round i+1.
  localparam logic [31:0] RCON [NR] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  // Forward S-box, index = input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for round r (1..NR); zero for any other value so an
  // out-of-range index never reads past the table.
  function automatic logic [31:0] get_rcon(input logic [3:0] r);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) begin
      if (r == 4'(i + 1)) v = RCON[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit forward AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Pure table lookup; synthesis maps it to a ROM or logic.
  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: takes the last round key and
// emits round keys NO_ROUNDS down to 0, one per output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Input side: key_valid/key_ready, key_ready high only in IDLE.
// Output side: rk_valid/rk_ready; while rk_valid is high and rk_ready low,
// round_key, round_idx and rk_last hold their values.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int KEY_LEN   = 128,
  parameter int NO_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_LEN-1:0] last_round_key,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [DATA_W-1:0]  round_key,
  output logic [3:0]         round_idx,
  output logic               rk_last
);

  localparam logic [3:0] LAST_IDX = 4'(NO_ROUNDS);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [3:0]        idx_q, idx_d;

  logic [31:0]       a0, a1, a2, a3;
  logic [31:0]       b0, b1, b2, b3;
  logic [31:0]       rot_w, sub_w;
  logic [DATA_W-1:0] prev_key;

  // One step back through the schedule: undo the word chaining, then
  // recover word 0 with the same SubWord/RotWord/RCON as forward expansion.
  always_comb begin
    a0       = key_q[127:96];
    a1       = key_q[95:64];
    a2       = key_q[63:32];
    a3       = key_q[31:0];
    b3       = a3 ^ a2;
    b2       = a2 ^ a1;
    b1       = a1 ^ a0;
    rot_w    = {b3[23:0], b3[31:24]};
    b0       = a0 ^ sub_w ^ get_rcon(idx_q);
    prev_key = {b0, b1, b2, b3};
  end

  for (genvar g = 0; g < NK; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*g +: 8]),
      .out_byte (sub_w[8*g +: 8])
    );
  end

  // Next-state logic: load in IDLE, step the key back on each accepted
  // output, return to IDLE after round 0 is taken.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = last_round_key;
          idx_d   = LAST_IDX;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q != 4'd0) begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, key and index registers; reset discards any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs come straight from the registers, so they are glitch-free and
  // naturally stable under backpressure.
  always_comb begin
    key_ready = (state_q == IDLE);
    rk_valid  = (state_q == EMIT);
    round_key = key_q;
    round_idx = idx_q;
    rk_last   = (state_q == EMIT) && (idx_q == 4'd0);
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: FIPS-197 A.1 vectors, random
// backpressure, busy reload, mid-sequence reset and forward/inverse round trip.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] last_round_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_last;

  aes_inv_key_sched dut (
    .clk            (clk),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .last_round_key (last_round_key),
    .rk_valid       (rk_valid),
    .rk_ready       (rk_ready),
    .round_key      (round_key),
    .round_idx      (round_idx),
    .rk_last        (rk_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [131:0]  exp_q[$];          // {round_idx, round_key}
  logic [7:0]    tb_sbox [256];
  logic [127:0]  fwd_rk [11];

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;
  vec_t a1_tab [11];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and the affine transform.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      tb_sbox[x] = s;
    end
  endtask

  // Forward AES-128 key expansion into fwd_rk[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) fwd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_valid      = 1'b1;
    last_round_key = k;
    check("key_ready_at_load", key_ready, 1);
    tick();
    key_valid = 1'b0;
    check("rk_valid_after_load", rk_valid, 1);
    check("round_idx_after_load", round_idx, 10);
  endtask

  task automatic push_a1();
    for (int i = 0; i < 11; i++) exp_q.push_back({a1_tab[i].idx, a1_tab[i].key});
  endtask

  task automatic push_fwd();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), fwd_rk[r]});
  endtask

  // Drain the scoreboard through the output handshake. ready_pct sets the
  // rk_ready duty; poke drives random key_valid during EMIT; stop_at >= 0
  // returns early once that round index is presented.
  task automatic collect(input int ready_pct, input bit poke, input int stop_at,
                         output bit stopped, output int cycles);
    bit           stall = 1'b0;
    logic [127:0] h_key;
    logic [3:0]   h_idx;
    logic         h_last;
    logic [131:0] e;
    stopped = 1'b0;
    cycles  = 0;
    while (exp_q.size() > 0) begin
      if (cycles > 400) begin
        n_checks++;
        n_errors++;
        $display("FAIL collect_timeout: got %0d outputs pending expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      cycles++;
      if (stall) begin
        check("stall_valid", rk_valid, 1);
        check("stall_key", round_key, h_key);
        check("stall_idx", round_idx, h_idx);
        check("stall_last", rk_last, h_last);
      end
      if (stop_at >= 0 && rk_valid && round_idx == 4'(stop_at)) begin
        stopped = 1'b1;
        break;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (poke) begin
        key_valid      = $urandom_range(1);
        last_round_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (key_valid) check("key_ready_busy", key_ready, 0);
      end
      if (rk_valid && rk_ready) begin
        e = exp_q.pop_front();
        check("round_idx", round_idx, e[131:128]);
        check("round_key", round_key, e[127:0]);
        check("rk_last", rk_last, e[131:128] == 4'd0);
      end
      stall  = rk_valid && !rk_ready;
      h_key  = round_key;
      h_idx  = round_idx;
      h_last = rk_last;
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_rk_last"}, rk_last, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] a1_keys [11];
    bit           stopped;
    int           cycles;

    a1_keys = '{
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
      128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605,
      128'h2b7e151628aed2a6abf7158809cf4f3c
    };
    for (int i = 0; i < 11; i++) a1_tab[i] = '{idx: 4'(10 - i), key: a1_keys[i]};

    build_sbox();

    reset          = 1'b1;
    key_valid      = 1'b0;
    rk_ready       = 1'b0;
    last_round_key = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_key_ready", key_ready, 1);
    check("rst_rk_valid", rk_valid, 0);
    check("rst_round_key", round_key, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_rk_last", rk_last, 0);
    reset = 1'b0;
    tick();

    // The bench model must reproduce the A.1 table before it is trusted.
    expand(a1_tab[10].key);
    for (int i = 0; i < 11; i++) check("model_vs_a1", fwd_rk[a1_tab[i].idx], a1_tab[i].key);

    // A.1 at full throughput: 11 back-to-back outputs.
    push_a1();
    load_key(a1_tab[0].key);
    collect(100, 1'b0, -1, stopped, cycles);
    check("a1_full_cycles", cycles, 11);
    check_idle("a1_full_after");

    // A.1 with random backpressure.
    push_a1();
    load_key(a1_tab[0].key);
    collect(45, 1'b0, -1, stopped, cycles);
    check_idle("a1_bp_after");

    // Busy reload attempts during EMIT are ignored.
    push_a1();
    load_key(a1_tab[0].key);
    collect(70, 1'b1, -1, stopped, cycles);
    check_idle("busy_after");

    // Reset mid-sequence at round 5, then a fresh load restarts at 10.
    push_a1();
    load_key(a1_tab[0].key);
    collect(60, 1'b0, 5, stopped, cycles);
    check("reset_reached_idx5", stopped, 1);
    reset = 1'b1;
    #1;
    check("midrst_key_ready", key_ready, 1);
    check("midrst_rk_valid", rk_valid, 0);
    check("midrst_round_key", round_key, 0);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_rk_last", rk_last, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    push_a1();
    load_key(a1_tab[0].key);
    collect(100, 1'b0, -1, stopped, cycles);
    check_idle("post_rst_after");

    // Round trip against the forward expansion for random cipher keys.
    for (int n = 0; n < 100; n++) begin
      expand({$urandom(), $urandom(), $urandom(), $urandom()});
      push_fwd();
      load_key(fwd_rk[10]);
      collect((n % 2 == 0) ? 100 : 60, 1'b0, -1, stopped, cycles);
    end
    check_idle("roundtrip_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
